// File: rtl/wb_sequencer_pkg.sv
// Shared types for the LC3 writeback sequencer.
//   wb_src_t      : writeback source select carried with each request
//   wb_req_t      : one pending writeback request as stored in the FIFO
//   head_state_t  : state of the in-order head controller
//   reg_mask()    : one-hot register mask used to build the scoreboard
package wb_sequencer_pkg;

  localparam int NUM_REGS = 8;

  typedef enum logic [1:0] {
    WB_ALU     = 2'd0,
    WB_PC      = 2'd1,
    WB_MEM     = 2'd2,
    WB_ILLEGAL = 2'd3
  } wb_src_t;

  typedef struct packed {
    logic [2:0] dr;
    wb_src_t    wctl;
    logic       we;
    logic       ind;
  } wb_req_t;

  // HEAD: deciding on the head entry; MEM1: waiting on a plain load;
  // IND1/IND2: waiting on the address and data reads of an indirect load.
  typedef enum logic [1:0] {
    HEAD,
    MEM1,
    IND1,
    IND2
  } head_state_t;

  function automatic logic [NUM_REGS-1:0] reg_mask(input logic [2:0] r);
    return {{(NUM_REGS-1){1'b0}}, 1'b1} << r;
  endfunction

endpackage

// File: rtl/wb_req_fifo.sv
// Synchronous FIFO of pending writeback requests.
// Every slot and its valid bit are exported so the owner can build a
// register scoreboard without extra bookkeeping.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   push/push_req: write one request (caller guarantees !full)
//   pop          : drop the head entry (caller guarantees !empty)
//   head         : oldest entry
//   count        : occupancy, 0..DEPTH
//   full, empty  : occupancy flags
//   entries/valid: all slots and their occupancy bits
module wb_req_fifo
  import wb_sequencer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  wb_req_t                  push_req,
  input  logic                     pop,
  output wb_req_t                  head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output wb_req_t                  entries [DEPTH],
  output logic [DEPTH-1:0]         valid
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else begin
      // Pointers are PTR_W bits wide with DEPTH a power of two, so they wrap
      // modulo DEPTH on their own.
      if (push) begin
        wr_ptr        <= wr_ptr + 1'b1;
        valid[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr        <= rd_ptr + 1'b1;
        valid[rd_ptr] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the payload array carries no reset; an entry's contents only
  // matter while its valid bit is set, and valid bits are reset above.
  always_ff @(posedge clock) begin
    if (push) entries[wr_ptr] <= push_req;
  end

  assign head  = entries[rd_ptr];
  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/wb_sequencer.sv
// In-order writeback controller for the LC3 writeback stage.
// Decoded requests queue in a small FIFO and retire strictly in program
// order; loads hold the head until memory reports completion (twice for
// an indirect load). A register scoreboard built from the queue lets
// decode stall on source-operand hazards.
//   clock, reset        : rising-edge clock, asynchronous active-high reset
//   issue_*             : request from decode, accepted when issue_ready
//   mem_complete        : one-cycle pulse, memory read finished for head
//   sr1, sr2 / hazard   : decode source registers and their hazard flag
//   reg_busy            : bit r set while a queued write targets r
//   enable_writeback,
//   W_control_in, dr    : registered write strobe toward the datapath
//   err                 : sticky protocol error (illegal select or stray
//                         mem_complete), cleared only by reset
module wb_sequencer
  import wb_sequencer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       issue_valid,
  output logic       issue_ready,
  input  logic [2:0] issue_dr,
  input  logic [1:0] issue_wctl,
  input  logic       issue_we,
  input  logic       issue_ind,
  input  logic       mem_complete,
  input  logic [2:0] sr1,
  input  logic [2:0] sr2,
  output logic       hazard,
  output logic [7:0] reg_busy,
  output logic       enable_writeback,
  output logic [1:0] W_control_in,
  output logic [2:0] dr,
  output logic       err
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_req_t          issue_req;
  wb_req_t          head;
  wb_req_t          entries [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PTR_W:0]   count;
  logic             full;
  logic             empty;
  logic             push;
  logic             retire;
  logic             fresh;
  head_state_t      state;

  assign issue_ready = !full;
  assign push        = issue_valid && !full;

  // An illegal select is still queued to keep program order, but it never
  // writes the register file.
  always_comb begin
    issue_req.dr   = issue_dr;
    issue_req.wctl = wb_src_t'(issue_wctl);
    issue_req.we   = issue_we && (issue_wctl != WB_ILLEGAL);
    issue_req.ind  = issue_ind;
  end

  wb_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_req (issue_req),
    .pop      (retire),
    .head     (head),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .entries  (entries),
    .valid    (valid)
  );

  // A request that lands directly at the head spends one cycle there before
  // the head controller acts on it; this is the stage boundary between
  // decode and writeback, and it gives the two-edge ALU latency.
  always_comb begin
    // NOTE: assign a default before the case so no path leaves retire
    // unassigned, which would otherwise infer a latch.
    retire = 1'b0;
    unique case (state)
      HEAD:       retire = !empty && !fresh && (head.wctl != WB_MEM);
      MEM1, IND2: retire = mem_complete;
      IND1:       retire = 1'b0;
      default:    retire = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= HEAD;
      fresh            <= 1'b0;
      enable_writeback <= 1'b0;
      W_control_in     <= 2'd0;
      dr               <= 3'd0;
      err              <= 1'b0;
    end else begin
      // NOTE: state and outputs are registered with non-blocking
      // assignments so every read above sees the pre-edge values.
      enable_writeback <= 1'b0;
      if (retire) begin
        enable_writeback <= head.we;
        W_control_in     <= head.wctl;
        dr               <= head.dr;
      end

      // The pushed entry is the next head when the FIFO will otherwise be
      // empty after this edge.
      fresh <= push && (retire ? (count == (PTR_W+1)'(1)) : (count == '0));

      if ((push && (issue_wctl == WB_ILLEGAL)) || (mem_complete && (state == HEAD)))
        err <= 1'b1;

      unique case (state)
        HEAD: if (!empty && !fresh && (head.wctl == WB_MEM))
                state <= head.ind ? IND1 : MEM1;
        MEM1: if (mem_complete) state <= HEAD;
        IND1: if (mem_complete) state <= IND2;
        IND2: if (mem_complete) state <= HEAD;
        default: state <= HEAD;
      endcase
    end
  end

  // Popped entries drop out of valid at the pop edge, so a register is
  // already clear in the cycle its write strobe is visible.
  always_comb begin
    reg_busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && entries[i].we) reg_busy = reg_busy | reg_mask(entries[i].dr);
    end
  end

  assign hazard = reg_busy[sr1] | reg_busy[sr2];

endmodule

// File: tb/tb_wb_sequencer.sv
// Self-checking bench for wb_sequencer: a queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_wb_sequencer;

  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       issue_valid;
  logic       issue_ready;
  logic [2:0] issue_dr;
  logic [1:0] issue_wctl;
  logic       issue_we;
  logic       issue_ind;
  logic       mem_complete;
  logic [2:0] sr1;
  logic [2:0] sr2;
  logic       hazard;
  logic [7:0] reg_busy;
  logic       enable_writeback;
  logic [1:0] W_control_in;
  logic [2:0] dr;
  logic       err;

  int checks   = 0;
  int failures = 0;
  bit armed    = 1'b0;

  wb_sequencer #(.DEPTH(DEPTH)) dut (
    .clock            (clock),
    .reset            (reset),
    .issue_valid      (issue_valid),
    .issue_ready      (issue_ready),
    .issue_dr         (issue_dr),
    .issue_wctl       (issue_wctl),
    .issue_we         (issue_we),
    .issue_ind        (issue_ind),
    .mem_complete     (mem_complete),
    .sr1              (sr1),
    .sr2              (sr2),
    .hazard           (hazard),
    .reg_busy         (reg_busy),
    .enable_writeback (enable_writeback),
    .W_control_in     (W_control_in),
    .dr               (dr),
    .err              (err)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each queued request remembers how many memory completions it still needs
  // and the edge from which the head may act on it ('act'): an ALU/PC head
  // retires at that edge, a load head accepts completions only after it.
  typedef struct {
    int dr;
    int wctl;
    bit we;
    int left;
    int act;
  } mreq_t;

  mreq_t      m_q[$];
  int         edge_k = 0;
  logic       m_en   = 1'b0;
  logic [1:0] m_w    = 2'd0;
  logic [2:0] m_dr   = 3'd0;
  logic       m_err  = 1'b0;

  function automatic logic [7:0] m_busy();
    logic [7:0] b;
    b = '0;
    foreach (m_q[i]) if (m_q[i].we) b[m_q[i].dr] = 1'b1;
    return b;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_q.delete();
      m_en  = 1'b0;
      m_w   = 2'd0;
      m_dr  = 3'd0;
      m_err = 1'b0;
    end else begin
      bit    ret;
      int    n0;
      mreq_t h;
      mreq_t e;
      ret = 1'b0;
      n0  = m_q.size();
      edge_k++;
      m_en = 1'b0;
      if (mem_complete) begin
        if (n0 > 0 && m_q[0].wctl == 2 && edge_k > m_q[0].act) begin
          m_q[0].left--;
          if (m_q[0].left == 0) ret = 1'b1;
        end else begin
          m_err = 1'b1;
        end
      end
      if (n0 > 0 && m_q[0].wctl != 2 && edge_k >= m_q[0].act) ret = 1'b1;
      if (ret) begin
        h    = m_q.pop_front();
        m_en = h.we;
        m_w  = 2'(h.wctl);
        m_dr = 3'(h.dr);
        if (m_q.size() > 0) m_q[0].act = edge_k + 1;
      end
      if (issue_valid && n0 < DEPTH) begin
        e.dr   = int'(issue_dr);
        e.wctl = int'(issue_wctl);
        e.we   = issue_we && (issue_wctl != 2'd3);
        e.left = (issue_wctl == 2'd2 && issue_ind) ? 2 : 1;
        e.act  = edge_k + 2;
        if (issue_wctl == 2'd3) m_err = 1'b1;
        m_q.push_back(e);
      end
    end
  end

  // Every-cycle comparison on the falling edge.
  always @(negedge clock) begin
    if (armed) begin
      logic [7:0] b;
      b = m_busy();
      check("cmp_enable", 32'(enable_writeback), 32'(m_en));
      check("cmp_wctl", 32'(W_control_in), 32'(m_w));
      check("cmp_dr", 32'(dr), 32'(m_dr));
      check("cmp_err", 32'(err), 32'(m_err));
      check("cmp_busy", 32'(reg_busy), 32'(b));
      check("cmp_hazard", 32'(hazard), 32'(b[sr1] | b[sr2]));
      check("cmp_ready", 32'(issue_ready), 32'(m_q.size() < DEPTH));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input int d, input int w, input bit we, input bit ind);
    issue_valid = 1'b1;
    issue_dr    = 3'(d);
    issue_wctl  = 2'(w);
    issue_we    = we;
    issue_ind   = ind;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    issue_valid  = 1'b0;
    issue_dr     = 3'd0;
    issue_wctl   = 2'd0;
    issue_we     = 1'b0;
    issue_ind    = 1'b0;
    mem_complete = 1'b0;
    sr1          = 3'd0;
    sr2          = 3'd0;
    tick();
    tick();
    reset = 1'b0;
    armed = 1'b1;

    check("reset_enable", 32'(enable_writeback), 32'd0);
    check("reset_busy", 32'(reg_busy), 32'd0);
    check("reset_ready", 32'(issue_ready), 32'd1);
    check("reset_err", 32'(err), 32'd0);

    // ALU burst
    issue(3, 0, 1, 0);
    tick();
    check("alu_busy0", 32'(reg_busy), 32'h08);
    issue(5, 1, 1, 0);
    tick();
    check("alu_busy1", 32'(reg_busy), 32'h28);
    check("alu_no_strobe", 32'(enable_writeback), 32'd0);
    idle();
    tick();
    check("alu_strobe0", {29'd0, enable_writeback, W_control_in}, {29'd0, 1'b1, 2'd0});
    check("alu_dr0", 32'(dr), 32'd3);
    check("alu_busy2", 32'(reg_busy), 32'h20);
    tick();
    check("alu_strobe1", {29'd0, enable_writeback, W_control_in}, {29'd0, 1'b1, 2'd1});
    check("alu_dr1", 32'(dr), 32'd5);
    check("alu_busy3", 32'(reg_busy), 32'h00);
    tick();
    check("alu_quiet", 32'(enable_writeback), 32'd0);

    // Ordering: ALU behind a pending load
    issue(2, 2, 1, 0);
    tick();
    issue(4, 0, 1, 0);
    tick();
    idle();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("ord_hold", 32'(enable_writeback), 32'd0);
    end
    check("ord_busy", 32'(reg_busy), 32'h14);
    mem_complete = 1'b1;
    tick();
    mem_complete = 1'b0;
    check("ord_ld_strobe", {29'd0, enable_writeback, W_control_in}, {29'd0, 1'b1, 2'd2});
    check("ord_ld_dr", 32'(dr), 32'd2);
    tick();
    check("ord_alu_strobe", {29'd0, enable_writeback, W_control_in}, {29'd0, 1'b1, 2'd0});
    check("ord_alu_dr", 32'(dr), 32'd4);
    tick();

    // LDI
    issue(7, 2, 1, 1);
    tick();
    idle();
    tick();
    tick();
    tick();
    mem_complete = 1'b1;
    tick();
    mem_complete = 1'b0;
    check("ldi_first_no_strobe", 32'(enable_writeback), 32'd0);
    check("ldi_busy", 32'(reg_busy), 32'h80);
    tick();
    tick();
    mem_complete = 1'b1;
    tick();
    mem_complete = 1'b0;
    check("ldi_strobe", 32'(enable_writeback), 32'd1);
    check("ldi_dr", 32'(dr), 32'd7);
    check("ldi_busy_clear", 32'(reg_busy), 32'h00);
    tick();
    check("ldi_single", 32'(enable_writeback), 32'd0);

    // Full FIFO
    for (int i = 0; i < DEPTH; i++) begin
      issue(i, 2, 1, 0);
      tick();
    end
    check("full_ready", 32'(issue_ready), 32'd0);
    check("full_busy", 32'(reg_busy), 32'h0F);
    issue(4, 2, 1, 0);
    tick();
    check("full_ignored", 32'(reg_busy), 32'h0F);
    mem_complete = 1'b1;
    tick();
    mem_complete = 1'b0;
    check("full_strobe", 32'(enable_writeback), 32'd1);
    check("full_strobe_dr", 32'(dr), 32'd0);
    check("full_ready_again", 32'(issue_ready), 32'd1);
    check("full_busy_pop", 32'(reg_busy), 32'h0E);
    tick();
    check("full_accept", 32'(reg_busy), 32'h1E);
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      mem_complete = 1'b1;
      tick();
      mem_complete = 1'b0;
      check("drain_strobe", 32'(enable_writeback), 32'd1);
    end
    check("drain_busy", 32'(reg_busy), 32'h00);
    check("drain_err", 32'(err), 32'd0);

    // Hazard
    issue(1, 2, 1, 0);
    tick();
    idle();
    sr1 = 3'd6;
    sr2 = 3'd1;
    #1;
    check("hazard_sr2", 32'(hazard), 32'd1);
    sr2 = 3'd2;
    #1;
    check("hazard_none", 32'(hazard), 32'd0);
    sr1 = 3'd1;
    #1;
    check("hazard_sr1", 32'(hazard), 32'd1);
    tick();
    tick();
    mem_complete = 1'b1;
    tick();
    mem_complete = 1'b0;
    check("hazard_clear", 32'(hazard), 32'd0);
    sr1 = 3'd0;
    sr2 = 3'd0;
    tick();

    // Illegal select
    pulse_reset();
    issue(6, 3, 1, 0);
    tick();
    idle();
    check("illegal_err", 32'(err), 32'd1);
    check("illegal_busy", 32'(reg_busy), 32'h00);
    tick();
    check("illegal_no_strobe0", 32'(enable_writeback), 32'd0);
    tick();
    check("illegal_no_strobe1", 32'(enable_writeback), 32'd0);
    tick();

    // Stray completion on an empty FIFO
    pulse_reset();
    check("stray_pre_err", 32'(err), 32'd0);
    mem_complete = 1'b1;
    tick();
    mem_complete = 1'b0;
    check("stray_err", 32'(err), 32'd1);
    check("stray_no_strobe", 32'(enable_writeback), 32'd0);
    tick();

    // Reset while in IND2 with three entries queued
    pulse_reset();
    issue(7, 2, 1, 1);
    tick();
    issue(1, 0, 1, 0);
    tick();
    issue(2, 0, 1, 0);
    tick();
    idle();
    tick();
    tick();
    mem_complete = 1'b1;
    tick();
    mem_complete = 1'b0;
    check("midop_busy", 32'(reg_busy), 32'h86);
    reset = 1'b1;
    #1;
    check("midop_enable", 32'(enable_writeback), 32'd0);
    check("midop_ready", 32'(issue_ready), 32'd1);
    check("midop_busy_clear", 32'(reg_busy), 32'h00);
    check("midop_outs", {27'd0, W_control_in, dr}, 32'd0);
    tick();
    reset = 1'b0;
    issue(5, 1, 1, 0);
    tick();
    idle();
    tick();
    tick();
    check("post_reset_strobe", {29'd0, enable_writeback, W_control_in}, {29'd0, 1'b1, 2'd1});
    check("post_reset_dr", 32'(dr), 32'd5);
    tick();
    tick();

    armed = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_sequencer.md
Name: wb_sequencer

Overview:
- In-order writeback controller for the LC3 writeback stage.
- Accepts decoded writeback requests (destination, source select, write flag, indirect flag) and holds them in a small FIFO.
- Retires requests in program order; memory-sourced requests wait for memory completion.
- Drives enable_writeback / W_control_in / dr toward the writeback datapath and exports a register scoreboard so decode can stall on sr1/sr2 hazards.

Parameters:
DEPTH, 4, pending-request FIFO entries (power of 2, >=2)
PTR_W, $clog2(DEPTH), FIFO pointer width (derived, not overridden)

Ports:
clock  input  1  sole clock, rising edge
reset  input  1  asynchronous, active-high reset
issue_valid  input  1  decode presents a request
issue_ready  output  1  FIFO can accept; equals !full
issue_dr  input  3  destination register
issue_wctl  input  2  source select: 0 aluout, 1 pcout, 2 memout, 3 illegal
issue_we  input  1  request writes the register file
issue_ind  input  1  memory request is indirect (LDI: two completions)
mem_complete  input  1  one-cycle pulse: memory read finished for head request
sr1  input  3  decode source register 1
sr2  input  3  decode source register 2
hazard  output  1  sr1 or sr2 matches a pending write
reg_busy  output  8  bit r set when any valid entry has we=1 and dr=r
enable_writeback  output  1  registered one-cycle write strobe
W_control_in  output  2  registered source select for the strobed write
dr  output  3  registered destination for the strobed write
err  output  1  sticky protocol-error flag

Behaviour:
- Reset (asynchronous, any time including mid-operation) clears:
  - FIFO pointers, count and all valid bits;
  - FSM state to HEAD;
  - all outputs: enable_writeback=0, W_control_in=0, dr=0, err=0.
  - Therefore hazard=0, reg_busy=0, issue_ready=1.
- Enqueue: on a clock edge with issue_valid && issue_ready. issue_valid while full is ignored; decode must hold the request.
- Illegal select: issue_wctl==3 enqueues with we forced to 0 and sets err.
- Enqueue and retire in the same cycle: count unchanged, both pointers advance.
- Head FSM:
  - HEAD: when the head is valid:
    - wctl!=2: retire this cycle.
    - wctl==2, ind=0: go to MEM1.
    - wctl==2, ind=1: go to IND1.
  - MEM1: mem_complete → retire, go to HEAD.
  - IND1: mem_complete → IND2 (address phase done).
  - IND2: mem_complete → retire, go to HEAD.
- Retire actions:
  - Pop the head.
  - At the next edge, register enable_writeback=we, W_control_in=wctl, dr=head dr.
  - Otherwise enable_writeback=0 each cycle; W_control_in and dr hold their last values.
- Latency:
  - ALU/PC request issued at edge N into an empty FIFO: becomes head after edge N, retires during cycle N+1, strobe is high for the cycle after edge N+2.
  - Memory request: strobe is high for the cycle after the edge that samples the final mem_complete.
- Throughput: at most one retire per cycle; back-to-back ALU requests produce back-to-back strobes.
- Ordering: younger ALU requests never overtake an older pending memory request.
- mem_complete with the head not in MEM1/IND1/IND2 (including an empty FIFO): ignored, sets err.
- err is cleared only by reset.
- Scoreboard:
  - reg_busy is combinational from valid FIFO entries.
  - An entry stops contributing in the cycle after it is popped, so it is clear when the strobe is visible.
  - hazard = reg_busy[sr1] | reg_busy[sr2].
- Pointers wrap modulo DEPTH; count is PTR_W+1 bits; full when count==DEPTH.

Decomposition:
- Shared package wb_sequencer_pkg holds:
  - wb_src_t enum: WB_ALU=2'd0, WB_PC=2'd1, WB_MEM=2'd2, WB_ILLEGAL=2'd3;
  - wb_req_t packed struct {dr, wctl, we, ind};
  - head FSM state enum {HEAD, MEM1, IND1, IND2}.
- One natural sub-module: wb_req_fifo. It is a synchronous FIFO of wb_req_t that exposes all entries for the scoreboard; the FSM, output registers and hazard logic stay at top level.

Test Plan:
- ALU burst: issue {dr=3,wctl=0,we=1} then {dr=5,wctl=1,we=1} on consecutive edges → strobes on two consecutive cycles with (W_control_in,dr)=(0,3) then (1,5); reg_busy 0x08 → 0x28 → 0x20 → 0x00.
- Ordering: issue LD {dr=2,wctl=2}, then ALU {dr=4,wctl=0}; mem_complete 6 cycles later → no strobe before it; then (2,2) strobe followed next cycle by (0,4).
- LDI: issue {dr=7,wctl=2,ind=1}; one mem_complete → no strobe, reg_busy[7]=1; second mem_complete → single strobe dr=7, reg_busy[7] clears.
- Full: issue DEPTH=4 LD requests with no completions → issue_ready=0 after the 4th; a 5th issue is ignored; one mem_complete with issue_valid held → one strobe and that cycle's issue is accepted.
- Hazard and errors:
  - pending dr=1 with sr2=1 → hazard=1.
  - stray mem_complete on an empty FIFO → err=1, no strobe.
  - issue wctl=3 → err=1, no write strobe.
- Reset mid-operation: assert reset while in IND2 with 3 entries queued → outputs 0, issue_ready=1 immediately; after release, a new ALU request retires normally.
